axis_blk_packer: RTL and testbench
==================================

// Module: axis_blk_packer
// PURPOSE
//   Packs an AXI4-Stream word stream into full cipher blocks for the AES core.
//   Optional per-word byte swap undoes the kernel's little-endian 32-bit word order.
//   Generalises the fixed 32-bit-word / 128-bit-block path:
//   - bus width and block width are parametrised;
//   - tlast may close a partial block, which is padded and tagged with its word count.
//   Sits between the s_axis DMA input and the AES core block input.
// PARAMETERS
//   BUS_W      32     s_axis_tdata width in bits (multiple of 8)
//   BLK_W      128    output block width in bits (multiple of BUS_W, N = BLK_W/BUS_W >= 2)
//   SWAP_BYTES 1      1: reverse byte order inside each accepted word; 0: pass through
//   PAD_BYTE   8'h00  fill byte for unused words of a tlast-terminated partial block
// PORTS
//   aclk           in   1                  clock, all logic on rising edge
//   reset          in   1                  synchronous reset, active-high
//   s_axis_tdata   in   BUS_W              input word
//   s_axis_tvalid  in   1                  input word valid
//   s_axis_tready  out  1                  input word accepted when tvalid & tready
//   s_axis_tlast   in   1                  last word of message
//   m_blk_data     out  BLK_W              packed block; first word in MSBs
//   m_blk_valid    out  1                  block valid
//   m_blk_ready    in   1                  block consumed when valid & ready
//   m_blk_last     out  1                  block closed by tlast
//   m_blk_words    out  $clog2(N+1)        number of real words in block (1..N)
// BEHAVIOUR
//   - Reset outputs:
//     - m_blk_valid=0, m_blk_last=0, m_blk_words=0, m_blk_data=0;
//     - internal word counter cnt=0, accumulator=0;
//     - s_axis_tready=1 from the first cycle after reset.
//   - Reset mid-block discards the partial accumulator and any held block; nothing is emitted.
//   - s_axis_tready = !m_blk_valid | m_blk_ready (combinational). Never depends on s_axis_tvalid.
//   - Accepted beat:
//     - word w = SWAP_BYTES ? byte-reversed tdata : tdata;
//     - w is written into word slot cnt, slot 0 = bits [BLK_W-1 -: BUS_W].
//   - Close condition: cnt==N-1 OR tlast on an accepted beat. On the same edge:
//     - m_blk_data <= accumulator with slot cnt = w; slots above cnt are filled with PAD_BYTE;
//     - m_blk_valid <= 1, m_blk_last <= tlast, m_blk_words <= cnt+1;
//     - cnt <= 0 and the accumulator is cleared.
//   - Otherwise an accepted beat does cnt <= cnt+1.
//   - Latency: block valid 1 cycle after the closing beat.
//   - Full rate (1 word/cycle) whenever m_blk_ready is held high.
//   - Output hold: while m_blk_valid & !m_blk_ready, all m_blk_* outputs are held stable.
//   - Handshake cycle:
//     - m_blk_valid & m_blk_ready with no new close -> m_blk_valid <= 0;
//     - handshake and close in the same cycle -> the new block replaces the old (valid stays 1).
//   - tlast on slot 0 -> single-word block, m_blk_words=1.
//   - tlast exactly on slot N-1 -> full block, m_blk_last=1, m_blk_words=N.
//   - A beat arriving while the held block is stalled waits; tdata is never dropped or overwritten.
//   - Parameter violations (BLK_W % BUS_W != 0, BUS_W % 8 != 0, N < 2) -> elaboration $error.
// TESTING
//   1 SWAP=1, beats 33221100, 77665544, BBAA9988, FFEEDDCC(last), ready=1
//     -> 1 cycle after beat 4: data=00112233_44556677_8899AABB_CCDDEEFF, last=1, words=4.
//   2 beats 33221100, 77665544(last)
//     -> data=00112233_44556677_00000000_00000000, last=1, words=2.
//   3 block held with m_blk_ready=0 for 10 cycles while 5 beats are offered
//     -> tready=0 throughout, m_blk_* stable;
//     -> after ready: next block = first 4 offered words, no loss or duplication.
//   4 8 contiguous beats, ready=1
//     -> tready constantly 1, m_blk_valid pulses 1 cycle after beat 4 and after beat 8.
//   5 reset pulse after 2 of 4 beats
//     -> m_blk_valid=0 next cycle; the following 4 beats form one clean block, words=4.
//   6 BUS_W=64, BLK_W=128, SWAP=0, beats 0011223344556677, 8899AABBCCDDEEFF(last)
//     -> data=00112233445566778899AABBCCDDEEFF, words=2.

Source files
------------

// File: rtl/axis_blk_packer.sv
// axis_blk_packer: packs an AXI4-Stream word stream into cipher blocks.
// Optional per-word byte swap; tlast closes a padded, word-counted block.
//
// Ports:
//   aclk, reset        clock (rising edge), synchronous active-high reset
//   s_axis_tdata       input word (BUS_W bits)
//   s_axis_tvalid      input word valid
//   s_axis_tready      input accepted when tvalid & tready
//   s_axis_tlast       last word of message
//   m_blk_data         packed block, first word in MSBs (BLK_W bits)
//   m_blk_valid        block valid
//   m_blk_ready        block consumed when valid & ready
//   m_blk_last         block was closed by tlast
//   m_blk_words        number of real words in the block (1..N)
module axis_blk_packer #(
   parameter int         BUS_W      = 32,
   parameter int         BLK_W      = 128,
   parameter bit         SWAP_BYTES = 1'b1,
   parameter logic [7:0] PAD_BYTE   = 8'h00
) (
   input  logic                               aclk,
   input  logic                               reset,
   input  logic [BUS_W-1:0]                   s_axis_tdata,
   input  logic                               s_axis_tvalid,
   output logic                               s_axis_tready,
   input  logic                               s_axis_tlast,
   output logic [BLK_W-1:0]                   m_blk_data,
   output logic                               m_blk_valid,
   input  logic                               m_blk_ready,
   output logic                               m_blk_last,
   output logic [$clog2(BLK_W/BUS_W+1)-1:0]   m_blk_words
);

   localparam int N  = BLK_W / BUS_W;
   localparam int NB = BUS_W / 8;
   localparam int CW = $clog2(N);
   localparam int WW = $clog2(N + 1);

   if ((BLK_W % BUS_W) != 0 || (BUS_W % 8) != 0 || N < 2) begin : g_param_err
      $error("axis_blk_packer: BLK_W must be a multiple of BUS_W, BUS_W of 8, N >= 2");
   end

   logic [CW-1:0]    cnt;
   logic [BLK_W-1:0] acc;
   logic [BLK_W-1:0] acc_nxt;
   logic [BLK_W-1:0] blk_nxt;
   logic [BUS_W-1:0] word;
   logic             accept;
   logic             close;

   // Output register can only take a new block once the held one leaves.
   assign s_axis_tready = !m_blk_valid | m_blk_ready;
   assign accept        = s_axis_tvalid & s_axis_tready;
   assign close         = accept & ((cnt == CW'(N - 1)) | s_axis_tlast);

   always_comb begin
      word = '0;
      for (int b = 0; b < NB; b++) begin
         if (SWAP_BYTES)
            word[8*b +: 8] = s_axis_tdata[8*(NB-1-b) +: 8];
         else
            word[8*b +: 8] = s_axis_tdata[8*b +: 8];
      end
   end

   // acc_nxt: accumulator with the new word dropped into slot cnt.
   // blk_nxt: same, but slots past cnt are padded for a closing block.
   always_comb begin
      acc_nxt = acc;
      blk_nxt = '0;
      for (int i = 0; i < N; i++) begin
         if (i < int'(cnt)) begin
            blk_nxt[BLK_W-1-i*BUS_W -: BUS_W] = acc[BLK_W-1-i*BUS_W -: BUS_W];
         end else if (i == int'(cnt)) begin
            blk_nxt[BLK_W-1-i*BUS_W -: BUS_W] = word;
            acc_nxt[BLK_W-1-i*BUS_W -: BUS_W] = word;
         end else begin
            blk_nxt[BLK_W-1-i*BUS_W -: BUS_W] = {NB{PAD_BYTE}};
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (reset) begin
         cnt         <= '0;
         acc         <= '0;
         m_blk_data  <= '0;
         m_blk_valid <= 1'b0;
         m_blk_last  <= 1'b0;
         m_blk_words <= '0;
      end else if (close) begin
         // A close can coincide with the old block's handshake; it replaces it.
         m_blk_data  <= blk_nxt;
         m_blk_valid <= 1'b1;
         m_blk_last  <= s_axis_tlast;
         m_blk_words <= WW'(cnt) + WW'(1);
         cnt         <= '0;
         acc         <= '0;
      end else begin
         if (m_blk_valid && m_blk_ready)
            m_blk_valid <= 1'b0;
         if (accept) begin
            acc <= acc_nxt;
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_axis_blk_packer.sv
// tb_axis_blk_packer: directed bench for axis_blk_packer.
// Checks a 32/128 swapping instance and a 64/128 pass-through instance.
module tb_axis_blk_packer;

   logic         aclk = 1'b0;
   logic         reset;

   logic [31:0]  tdata;
   logic         tvalid;
   logic         tready;
   logic         tlast;
   logic [127:0] bdata;
   logic         bvalid;
   logic         bready;
   logic         blast;
   logic [2:0]   bwords;

   logic [63:0]  t6_tdata;
   logic         t6_tvalid;
   logic         t6_tready;
   logic         t6_tlast;
   logic [127:0] b6_data;
   logic         b6_valid;
   logic         b6_ready;
   logic         b6_last;
   logic [1:0]   b6_words;

   int tests = 0;
   int fails = 0;

   always #5 aclk = ~aclk;

   axis_blk_packer #(
      .BUS_W(32), .BLK_W(128), .SWAP_BYTES(1'b1), .PAD_BYTE(8'h00)
   ) u_dut (
      .aclk(aclk), .reset(reset),
      .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
      .s_axis_tready(tready), .s_axis_tlast(tlast),
      .m_blk_data(bdata), .m_blk_valid(bvalid),
      .m_blk_ready(bready), .m_blk_last(blast),
      .m_blk_words(bwords)
   );

   axis_blk_packer #(
      .BUS_W(64), .BLK_W(128), .SWAP_BYTES(1'b0), .PAD_BYTE(8'h00)
   ) u_dut64 (
      .aclk(aclk), .reset(reset),
      .s_axis_tdata(t6_tdata), .s_axis_tvalid(t6_tvalid),
      .s_axis_tready(t6_tready), .s_axis_tlast(t6_tlast),
      .m_blk_data(b6_data), .m_blk_valid(b6_valid),
      .m_blk_ready(b6_ready), .m_blk_last(b6_last),
      .m_blk_words(b6_words)
   );

   task automatic send(input logic [31:0] d, input logic l);
      tdata  = d;
      tlast  = l;
      tvalid = 1'b1;
      @(posedge aclk);
      #1;
   endtask

   task automatic idle(input int n);
      tvalid = 1'b0;
      tlast  = 1'b0;
      repeat (n) begin
         @(posedge aclk);
         #1;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(posedge aclk);
      #1;
      tests++;
      if (bvalid !== 1'b0) begin
         fails++;
         $display("FAIL reset_valid: got %b want 0", bvalid);
      end
      tests++;
      if (blast !== 1'b0 || bwords !== 3'd0) begin
         fails++;
         $display("FAIL reset_last_words: got %b/%0d want 0/0", blast, bwords);
      end
      tests++;
      if (bdata !== 128'h0) begin
         fails++;
         $display("FAIL reset_data: got %h want 0", bdata);
      end
      tests++;
      if (b6_valid !== 1'b0 || b6_data !== 128'h0) begin
         fails++;
         $display("FAIL reset_dut64: got %b/%h want 0/0", b6_valid, b6_data);
      end
      reset = 1'b0;
      @(posedge aclk);
      #1;
      tests++;
      if (tready !== 1'b1) begin
         fails++;
         $display("FAIL reset_tready: got %b want 1", tready);
      end
   endtask

   task automatic test_full_swap;
      bready = 1'b1;
      send(32'h33221100, 1'b0);
      send(32'h77665544, 1'b0);
      send(32'hBBAA9988, 1'b0);
      tests++;
      if (bvalid !== 1'b0) begin
         fails++;
         $display("FAIL full_early_valid: got %b want 0", bvalid);
      end
      send(32'hFFEEDDCC, 1'b1);
      tests++;
      if (bvalid !== 1'b1 ||
          bdata !== 128'h00112233_44556677_8899AABB_CCDDEEFF) begin
         fails++;
         $display("FAIL full_data: got %b/%h want 1/00112233445566778899aabbccddeeff",
                  bvalid, bdata);
      end
      tests++;
      if (blast !== 1'b1 || bwords !== 3'd4) begin
         fails++;
         $display("FAIL full_last_words: got %b/%0d want 1/4", blast, bwords);
      end
      idle(1);
      tests++;
      if (bvalid !== 1'b0) begin
         fails++;
         $display("FAIL full_drop: got %b want 0", bvalid);
      end
      idle(1);
   endtask

   task automatic test_partial;
      send(32'h33221100, 1'b0);
      send(32'h77665544, 1'b1);
      tests++;
      if (bvalid !== 1'b1 ||
          bdata !== 128'h00112233_44556677_00000000_00000000) begin
         fails++;
         $display("FAIL partial_data: got %b/%h want 1/00112233445566770000000000000000",
                  bvalid, bdata);
      end
      tests++;
      if (blast !== 1'b1 || bwords !== 3'd2) begin
         fails++;
         $display("FAIL partial_last_words: got %b/%0d want 1/2", blast, bwords);
      end
      idle(2);
   endtask

   task automatic test_stall;
      logic [31:0] x [5];
      x[0] = 32'h13121110;
      x[1] = 32'h17161514;
      x[2] = 32'h1B1A1918;
      x[3] = 32'h1F1E1D1C;
      x[4] = 32'h23222120;
      bready = 1'b0;
      send(32'h03020100, 1'b0);
      send(32'h07060504, 1'b0);
      send(32'h0B0A0908, 1'b0);
      send(32'h0F0E0D0C, 1'b0);
      tdata  = x[0];
      tlast  = 1'b0;
      tvalid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tests++;
         if (tready !== 1'b0 || bvalid !== 1'b1) begin
            fails++;
            $display("FAIL stall_hs cyc%0d: got tready=%b valid=%b want 0/1",
                     c, tready, bvalid);
         end
         tests++;
         if (bdata !== 128'h00010203_04050607_08090A0B_0C0D0E0F ||
             bwords !== 3'd4 || blast !== 1'b0) begin
            fails++;
            $display("FAIL stall_hold cyc%0d: got %h/%0d/%b want 000102030405060708090a0b0c0d0e0f/4/0",
                     c, bdata, bwords, blast);
         end
         @(posedge aclk);
         #1;
      end
      bready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         send(x[i], 1'b0);
         if (i == 0) begin
            tests++;
            if (bvalid !== 1'b0) begin
               fails++;
               $display("FAIL stall_release: got %b want 0", bvalid);
            end
         end
      end
      tests++;
      if (bvalid !== 1'b1 ||
          bdata !== 128'h10111213_14151617_18191A1B_1C1D1E1F ||
          bwords !== 3'd4) begin
         fails++;
         $display("FAIL stall_next: got %b/%h/%0d want 1/101112131415161718191a1b1c1d1e1f/4",
                  bvalid, bdata, bwords);
      end
      send(x[4], 1'b1);
      tests++;
      if (bvalid !== 1'b1 ||
          bdata !== 128'h20212223_00000000_00000000_00000000 ||
          bwords !== 3'd1 || blast !== 1'b1) begin
         fails++;
         $display("FAIL single_word: got %b/%h/%0d/%b want 1/20212223000000000000000000000000/1/1",
                  bvalid, bdata, bwords, blast);
      end
      idle(2);
   endtask

   task automatic test_back_to_back;
      logic [31:0] d;
      bready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tests++;
         if (tready !== 1'b1) begin
            fails++;
            $display("FAIL b2b_tready beat%0d: got %b want 1", i, tready);
         end
         d = {4{8'(8'hA0 + i)}};
         send(d, 1'b0);
         tests++;
         if (bvalid !== (i == 3 || i == 7)) begin
            fails++;
            $display("FAIL b2b_valid beat%0d: got %b want %b", i, bvalid, (i == 3 || i == 7));
         end
         if (i == 3) begin
            tests++;
            if (bdata !== 128'hA0A0A0A0_A1A1A1A1_A2A2A2A2_A3A3A3A3 ||
                bwords !== 3'd4 || blast !== 1'b0) begin
               fails++;
               $display("FAIL b2b_blk0: got %h/%0d/%b want a0a0a0a0a1a1a1a1a2a2a2a2a3a3a3a3/4/0",
                        bdata, bwords, blast);
            end
         end
         if (i == 7) begin
            tests++;
            if (bdata !== 128'hA4A4A4A4_A5A5A5A5_A6A6A6A6_A7A7A7A7 ||
                bwords !== 3'd4 || blast !== 1'b0) begin
               fails++;
               $display("FAIL b2b_blk1: got %h/%0d/%b want a4a4a4a4a5a5a5a5a6a6a6a6a7a7a7a7/4/0",
                        bdata, bwords, blast);
            end
         end
      end
      idle(2);
   endtask

   task automatic test_mid_reset;
      bready = 1'b1;
      send(32'hD0D0D0D0, 1'b0);
      send(32'hD1D1D1D1, 1'b0);
      tvalid = 1'b0;
      reset  = 1'b1;
      @(posedge aclk);
      #1;
      reset = 1'b0;
      tests++;
      if (bvalid !== 1'b0) begin
         fails++;
         $display("FAIL midreset_valid: got %b want 0", bvalid);
      end
      send(32'hE0E0E0E0, 1'b0);
      send(32'hE1E1E1E1, 1'b0);
      send(32'hE2E2E2E2, 1'b0);
      tests++;
      if (bvalid !== 1'b0) begin
         fails++;
         $display("FAIL midreset_early: got %b want 0", bvalid);
      end
      send(32'hE3E3E3E3, 1'b0);
      tests++;
      if (bvalid !== 1'b1 ||
          bdata !== 128'hE0E0E0E0_E1E1E1E1_E2E2E2E2_E3E3E3E3 ||
          bwords !== 3'd4) begin
         fails++;
         $display("FAIL midreset_blk: got %b/%h/%0d want 1/e0e0e0e0e1e1e1e1e2e2e2e2e3e3e3e3/4",
                  bvalid, bdata, bwords);
      end
      idle(2);
   endtask

   task automatic test_bus64;
      b6_ready  = 1'b1;
      t6_tdata  = 64'h0011223344556677;
      t6_tlast  = 1'b0;
      t6_tvalid = 1'b1;
      @(posedge aclk);
      #1;
      tests++;
      if (b6_valid !== 1'b0) begin
         fails++;
         $display("FAIL bus64_early: got %b want 0", b6_valid);
      end
      t6_tdata = 64'h8899AABBCCDDEEFF;
      t6_tlast = 1'b1;
      @(posedge aclk);
      #1;
      t6_tvalid = 1'b0;
      t6_tlast  = 1'b0;
      tests++;
      if (b6_valid !== 1'b1 ||
          b6_data !== 128'h00112233445566778899AABBCCDDEEFF) begin
         fails++;
         $display("FAIL bus64_data: got %b/%h want 1/00112233445566778899aabbccddeeff",
                  b6_valid, b6_data);
      end
      tests++;
      if (b6_words !== 2'd2 || b6_last !== 1'b1) begin
         fails++;
         $display("FAIL bus64_words: got %0d/%b want 2/1", b6_words, b6_last);
      end
      @(posedge aclk);
      #1;
   endtask

   initial begin
      reset     = 1'b1;
      tdata     = '0;
      tvalid    = 1'b0;
      tlast     = 1'b0;
      bready    = 1'b1;
      t6_tdata  = '0;
      t6_tvalid = 1'b0;
      t6_tlast  = 1'b0;
      b6_ready  = 1'b1;
      test_reset();
      test_full_swap();
      test_partial();
      test_stall();
      test_back_to_back();
      test_mid_reset();
      test_bus64();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
